// File: rtl/l2_fwd_stall_buf_pkg.sv
// Shared types, message codes and state encoding for the L2 forward stall buffer.
package l2_fwd_stall_buf_pkg;

  localparam int unsigned N_REQS    = 4;
  localparam int unsigned REQS_BITS = $clog2(N_REQS);

  localparam int unsigned MSG_W  = 3;
  localparam int unsigned ADDR_W = 26;
  localparam int unsigned ID_W   = 4;

  typedef logic [MSG_W-1:0]  mix_msg_t;
  typedef logic [ADDR_W-1:0] line_addr_t;
  typedef logic [ID_W-1:0]   cache_id_t;

  localparam mix_msg_t FWD_GETS   = 3'd1;
  localparam mix_msg_t FWD_GETM   = 3'd2;
  localparam mix_msg_t FWD_INV    = 3'd3;
  localparam mix_msg_t FWD_PUTACK = 3'd4;

  typedef logic [1:0] l2_fwd_stall_state_t;

  localparam l2_fwd_stall_state_t ST_IDLE  = 2'd0;
  localparam l2_fwd_stall_state_t ST_PEEK  = 2'd1;
  localparam l2_fwd_stall_state_t ST_STALL = 2'd2;
  localparam l2_fwd_stall_state_t ST_OUT   = 2'd3;

endpackage

// File: rtl/l2_fwd_stall_buf.sv
// Single-entry holding stage between the L2 forward queue and the forward handler.
// Optional stall watchdog enabled by defining L2_FWD_STALL_TIMEOUT_EN.
module l2_fwd_stall_buf
  import l2_fwd_stall_buf_pkg::*;
`ifdef L2_FWD_STALL_TIMEOUT_EN
#(
  parameter int unsigned STALL_TIMEOUT = 1024
)
`endif
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fwd_in_valid,
  output logic                 fwd_in_ready,
  input  mix_msg_t             fwd_in_coh_msg,
  input  line_addr_t           fwd_in_addr,
  input  cache_id_t            fwd_in_req_id,
  output logic                 peek_fwd_req,
  input  logic                 set_fwd_stall,
  input  logic                 clr_fwd_stall,
  input  logic                 set_fwd_stall_i,
  input  logic [REQS_BITS-1:0] fwd_stall_i_wr_data,
  input  logic                 req_done,
  input  logic [REQS_BITS-1:0] req_done_i,
  output logic                 fwd_out_valid,
  input  logic                 fwd_out_ready,
  output mix_msg_t             fwd_out_coh_msg,
  output line_addr_t           fwd_out_addr,
  output cache_id_t            fwd_out_req_id,
  output logic                 fwd_out_reqs_hit,
  output logic [REQS_BITS-1:0] fwd_out_reqs_i,
  output logic                 fwd_stall,
  output logic [REQS_BITS-1:0] fwd_stall_i
`ifdef L2_FWD_STALL_TIMEOUT_EN
  ,
  output logic                 stall_timeout
`endif
);

  l2_fwd_stall_state_t  state, state_nxt;
  logic                 out_valid_nxt, reqs_hit_nxt, stall_nxt;
  logic [REQS_BITS-1:0] reqs_i_nxt, stall_i_nxt;
  logic                 accept;

  assign fwd_in_ready = (state == ST_IDLE) && !rst;
  assign accept       = fwd_in_valid && fwd_in_ready;

  // Next-state and next-output decode
  always_comb begin
    state_nxt     = state;
    out_valid_nxt = fwd_out_valid;
    reqs_hit_nxt  = fwd_out_reqs_hit;
    reqs_i_nxt    = fwd_out_reqs_i;
    stall_nxt     = fwd_stall;
    stall_i_nxt   = fwd_stall_i;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_PEEK;
      end
      ST_PEEK: begin
        state_nxt     = ST_OUT;
        out_valid_nxt = 1'b1;
        reqs_hit_nxt  = 1'b0;
        reqs_i_nxt    = '0;
        if (set_fwd_stall_i && set_fwd_stall) begin
          // A retirement of the same entry in the lookup cycle makes parking pointless.
          if (!(req_done && (req_done_i == fwd_stall_i_wr_data))) begin
            state_nxt     = ST_STALL;
            out_valid_nxt = 1'b0;
            stall_nxt     = 1'b1;
            stall_i_nxt   = fwd_stall_i_wr_data;
          end
        end else if (set_fwd_stall_i && clr_fwd_stall) begin
          reqs_hit_nxt = 1'b1;
          reqs_i_nxt   = fwd_stall_i_wr_data;
        end
      end
      ST_STALL: begin
        if (req_done && (req_done_i == fwd_stall_i)) begin
          state_nxt     = ST_OUT;
          out_valid_nxt = 1'b1;
          reqs_hit_nxt  = 1'b0;
          reqs_i_nxt    = '0;
          stall_nxt     = 1'b0;
        end
      end
      ST_OUT: begin
        if (fwd_out_ready) begin
          state_nxt     = ST_IDLE;
          out_valid_nxt = 1'b0;
          reqs_hit_nxt  = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      peek_fwd_req     <= 1'b0;
      fwd_out_valid    <= 1'b0;
      fwd_out_reqs_hit <= 1'b0;
      fwd_out_reqs_i   <= '0;
      fwd_stall        <= 1'b0;
      fwd_stall_i      <= '0;
      fwd_out_coh_msg  <= '0;
      fwd_out_addr     <= '0;
      fwd_out_req_id   <= '0;
    end else begin
      state            <= state_nxt;
      peek_fwd_req     <= (state_nxt == ST_PEEK);
      fwd_out_valid    <= out_valid_nxt;
      fwd_out_reqs_hit <= reqs_hit_nxt;
      fwd_out_reqs_i   <= reqs_i_nxt;
      fwd_stall        <= stall_nxt;
      fwd_stall_i      <= stall_i_nxt;
      if (accept) begin
        fwd_out_coh_msg <= fwd_in_coh_msg;
        fwd_out_addr    <= fwd_in_addr;
        fwd_out_req_id  <= fwd_in_req_id;
      end
    end
  end

`ifdef L2_FWD_STALL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(STALL_TIMEOUT + 1);

  logic [CNT_W-1:0] stall_cnt;

  // Saturating count of cycles spent parked; flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else if (state != ST_STALL) begin
      stall_cnt <= '0;
    end else begin
      if (stall_cnt != CNT_W'(STALL_TIMEOUT)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (stall_cnt >= CNT_W'(STALL_TIMEOUT - 1)) stall_timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/l2_fwd_stall_buf.md
Name: l2_fwd_stall_buf

Overview:
- Single-entry holding stage between the L2 forward-input queue and the L2 forward-handling FSM.
- Accepts one forwarded coherence message and issues a PEEK_FWD lookup against the request buffer.
- If an outstanding request on the same line requires it, the message is parked until that request retires, then replayed.
- Otherwise the message is passed straight to the handler with the lookup hit/index annotation.

Parameters:
- N_REQS, 4, request-buffer entries.
- REQS_BITS, 2, clog2(N_REQS).
- STALL_TIMEOUT, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- fwd_in_valid  in  1  forward message valid.
- fwd_in_ready  out  1  buffer can accept.
- fwd_in_coh_msg  in  mix_msg_t  forward coherence message type.
- fwd_in_addr  in  line_addr_t  line address.
- fwd_in_req_id  in  cache_id_t  requester id.
- peek_fwd_req  out  1  ask controller to drive L2_REQS_PEEK_FWD this cycle.
- set_fwd_stall  in  1  lookup result: park message.
- clr_fwd_stall  in  1  lookup result: hit, no park.
- set_fwd_stall_i  in  1  lookup result valid.
- fwd_stall_i_wr_data  in  REQS_BITS  matching request index.
- req_done  in  1  pulse: a request-buffer entry retired (state to INVALID).
- req_done_i  in  REQS_BITS  index of retired entry.
- fwd_out_valid  out  1  message valid to handler.
- fwd_out_ready  in  1  handler accepts.
- fwd_out_coh_msg  out  mix_msg_t  message type.
- fwd_out_addr  out  line_addr_t  line address.
- fwd_out_req_id  out  cache_id_t  requester id.
- fwd_out_reqs_hit  out  1  message collided with a live request (non-parked hit).
- fwd_out_reqs_i  out  REQS_BITS  colliding request index.
- fwd_stall  out  1  a message is parked.
- fwd_stall_i  out  REQS_BITS  request index the parked message waits on.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high. Every register resets on the clk edge while rst=1.
- Reset values: state=IDLE; all fwd_out_* = 0; fwd_stall=0; fwd_stall_i=0; peek_fwd_req=0; held message cleared.
- fwd_in_ready = (state==IDLE) && !rst.
- FSM states: IDLE, PEEK, STALL, OUT.
- IDLE: on fwd_in_valid && fwd_in_ready, latch msg/addr/id and go to PEEK. Latency is one cycle.
- PEEK: peek_fwd_req=1 for exactly one cycle. Sample set_fwd_stall, clr_fwd_stall and fwd_stall_i_wr_data in the same cycle; results are combinational from the request buffer.
  - set_fwd_stall=1: fwd_stall<=1, fwd_stall_i<=fwd_stall_i_wr_data, go to STALL.
  - clr_fwd_stall=1: fwd_out_reqs_hit<=1, fwd_out_reqs_i<=index, go to OUT.
  - Neither set: reqs_hit<=0, reqs_i<=0, go to OUT.
  - set_fwd_stall_i=0 in PEEK is a protocol error: treat as a miss and go to OUT.
- STALL: wait for req_done && req_done_i==fwd_stall_i.
  - On match: fwd_stall<=0, fwd_out_reqs_hit<=0, go to OUT. The replay is treated as no-collision because the line is now resident or evicted.
  - req_done for another index is ignored.
- PEEK-cycle race: if set_fwd_stall=1 and req_done matches fwd_stall_i_wr_data in that same cycle, skip STALL and go to OUT with hit=0. fwd_stall stays 0.
- OUT: fwd_out_valid=1, payload stable until fwd_out_ready.
  - On handshake: clear fwd_out_valid and reqs_hit, return to IDLE.
  - No new message is accepted in the handshake cycle; the minimum occupancy is 3 cycles per message.
- Only one message is in flight at a time. Back-pressure reaches the input through fwd_in_ready=0.
- Reset mid-operation: a held or parked message is discarded, with no output and no error flag.

Optional Feature:
- Macro: L2_FWD_STALL_TIMEOUT_EN.
- With the macro: adds output stall_timeout (1 bit, sticky, reset 0) and a clog2(STALL_TIMEOUT+1)-bit counter.
  - The counter is cleared on entry to STALL and increments each STALL cycle, saturating.
  - When it reaches STALL_TIMEOUT, stall_timeout<=1 and stays set until rst. The FSM keeps waiting.
- Without the macro: no port, no counter, identical FSM behaviour.

Decomposition:
- Shared package/header: mix_msg_t, line_addr_t, cache_id_t, FWD_* message codes, REQS_BITS/N_REQS, and the state encoding l2_fwd_stall_state_t.
- Sub-module: none needed. The optional counter lives inline under the ifdef.

Test Plan:
- Miss path: FWD_GETS at addr 0x1234 and set_fwd_stall=clr=0 in PEEK → fwd_out_valid 2 cycles after accept with reqs_hit=0 and payload 0x1234.
- Hit, no park: FWD_INV with clr_fwd_stall=1 and index 2 → OUT with reqs_hit=1, reqs_i=2; fwd_stall stays 0.
- Park/replay: FWD_GETM with set_fwd_stall=1 and index 3. Then req_done for index 1 (ignored), then req_done for index 3 after 10 cycles → fwd_stall=1 for 10 cycles, then fwd_out_valid next cycle with hit=0.
- Race: set_fwd_stall=1 for index 0 together with req_done_i=0 in the PEEK cycle → direct to OUT; fwd_stall never asserts.
- Back-pressure/reset: fwd_out_ready=0 for 5 cycles keeps payload stable and fwd_in_ready=0. Asserting rst during STALL → all outputs 0 next cycle, fwd_in_ready=1 after rst drops.
- Timeout (macro on, STALL_TIMEOUT=8): park with no req_done → stall_timeout rises after 8 STALL cycles and stays high after the later replay.
